// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it, and serves two ID read ports with same-cycle write-through bypass.
module wb_regfile #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wwreg,
    input  logic             wm2reg,
    input  logic [4:0]       wdestReg,
    input  logic [WIDTH-1:0] wr,
    input  logic [WIDTH-1:0] wdo,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] wbData,
    output logic             wbValid,
    output logic [CNTW-1:0]  wbCount
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             commit_c;

    assign wbData   = wm2reg ? wdo : wr;
    // Reset blocks both the write and the bypass; r0 is never written.
    assign commit_c = rstn && wwreg && (wdestReg != 5'd0);

    // Register array, commit strobe and committed-write counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            regs    <= '{default: '0};
            wbValid <= 1'b0;
            wbCount <= '0;
        end else begin
            if (commit_c) begin
                regs[wdestReg] <= wbData;
                wbCount        <= wbCount + CNTW'(1);
            end
            wbValid <= commit_c;
        end
    end

    // Read port A with write-through bypass
    always_comb begin
        qa = '0;
        if (rs != 5'd0) begin
            if (commit_c && (wdestReg == rs)) qa = wbData;
            else                              qa = regs[rs];
        end
    end

    // Read port B with write-through bypass
    always_comb begin
        qb = '0;
        if (rt != 5'd0) begin
            if (commit_c && (wdestReg == rt)) qb = wbData;
            else                              qb = regs[rt];
        end
    end

endmodule
